alarm_ring_ctl: RTL

//  Alarm engine of the digital clock. Produces the alarm_ringing level that the mode

---
 rtl/alarm_ring_ctl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alarm_ring_ctl.sv
// Alarm engine: time match, ring/auto-silence sequencing and buzzer square wave.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_ring_ctl #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned BEEP_HALF   = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alm_hour,
    input  logic [5:0] alm_min,
    input  logic       alarm_en,
    input  logic [1:0] mode,
    input  logic       stop_key,
    input  logic       snooze_key,
    output logic       alarm_ringing,
    output logic       buzzer,
    output logic       snooze_active
);

    localparam int unsigned RING_W = $clog2(RING_SECS + 1);
    localparam int unsigned SNZ_W  = $clog2(SNOOZE_SECS + 1);
    localparam int unsigned DIV_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BEEP_HALF - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRinging
`ifdef ALARM_SNOOZE_EN
        ,
        StSnooze
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                buzzer_q, buzzer_d;
    logic                match;
    logic                stay_ringing;

`ifdef ALARM_SNOOZE_EN
    localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_SECS - 1);
    logic [SNZ_W-1:0]    snz_cnt_q, snz_cnt_d;
`else
    logic [SNZ_W-1:0]    unused_snz;
    assign unused_snz = SNZ_W'(SNOOZE_SECS) & {SNZ_W{snooze_key}};
`endif

    // SET (01) and ALARM_SET (11) both have mode[0] set and must not trigger.
    assign match = sec_tick & alarm_en & ~mode[0]
                 & (cur_hour == alm_hour) & (cur_min == alm_min) & (cur_sec == 6'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ring_cnt_q <= '0;
            div_q      <= '0;
            buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            div_q      <= div_d;
            buzzer_q   <= buzzer_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (match) state_d = StRinging;
            end
            StRinging: begin
                if (!alarm_en || stop_key) begin
                    state_d = StIdle;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze_key) begin
                    state_d = StSnooze;
`endif
                end else if (sec_tick && ring_cnt_q == RING_LAST) begin
                    state_d = StIdle;
                end
            end
`ifdef ALARM_SNOOZE_EN
            StSnooze: begin
                if (!alarm_en || stop_key) begin
                    state_d = StIdle;
                end else if (sec_tick && snz_cnt_q == SNZ_LAST) begin
                    state_d = StRinging;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Counters only advance while a state is held; any transition clears them.
    assign stay_ringing = (state_q == StRinging) && (state_d == StRinging);

    always_comb begin
        ring_cnt_d = '0;
        div_d      = '0;
        buzzer_d   = 1'b0;
        if (stay_ringing) begin
            ring_cnt_d = ring_cnt_q + RING_W'(sec_tick);
            if (div_q == DIV_LAST) begin
                div_d    = '0;
                buzzer_d = ~buzzer_q;
            end else begin
                div_d    = div_q + 1'b1;
                buzzer_d = buzzer_q;
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_comb begin
        snz_cnt_d = '0;
        if (state_q == StSnooze && state_d == StSnooze) begin
            snz_cnt_d = snz_cnt_q + SNZ_W'(sec_tick);
        end
    end
`endif

    always_comb begin
        alarm_ringing = (state_q == StRinging);
        buzzer        = buzzer_q;
`ifdef ALARM_SNOOZE_EN
        snooze_active = (state_q == StSnooze);
`else
        snooze_active = 1'b0;
`endif
    end

endmodule
